// File: rtl/mrv32_pkg.sv
// Shared constants and types for the mrv32 data-memory path.
package mrv32_pkg;

    localparam int unsigned MEM_BYTES          = 1024;
    localparam int unsigned ADDR_WIDTH         = 16;
    localparam int unsigned RD_LATENCY_DEFAULT = 1;

    localparam logic [3:0] WSTRB_NONE = 4'b0000;
    localparam logic [3:0] WSTRB_B    = 4'b0001;
    localparam logic [3:0] WSTRB_H    = 4'b0011;
    localparam logic [3:0] WSTRB_W    = 4'b1111;

    typedef enum logic {
        RSP_IDLE = 1'b0,
        RSP_WAIT = 1'b1
    } rsp_state_t;

endpackage

// File: rtl/mrv32_dmem_bank.sv
// Data RAM: word array with a byte-strobed bus write port, a full-word init
// write port that wins on collision, and one registered read port.
module mrv32_dmem_bank #(
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned IDX_WIDTH = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bus_we,
    input  logic [IDX_WIDTH-1:0] bus_idx,
    input  logic [3:0]           bus_wstrb,
    input  logic [31:0]          bus_wdata,
    input  logic                 init_we,
    input  logic [IDX_WIDTH-1:0] init_idx,
    input  logic [31:0]          init_data,
    input  logic                 rd_en,
    input  logic [IDX_WIDTH-1:0] rd_idx,
    output logic [31:0]          rd_data
);

    localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [31:0] mem [MEM_WORDS];

    logic bus_ok_c;
    logic init_ok_c;
    logic rd_ok_c;
    logic bus_go_c;

    // Range checks done at full index width so oversized indices never alias.
    assign bus_ok_c  = (32'(bus_idx)  < MEM_WORDS);
    assign init_ok_c = (32'(init_idx) < MEM_WORDS);
    assign rd_ok_c   = (32'(rd_idx)   < MEM_WORDS);

    // Init replaces the whole word, so a colliding bus write is suppressed.
    assign bus_go_c = bus_we && bus_ok_c && !(init_we && init_ok_c && (init_idx == bus_idx));

    // RAM write ports; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (bus_go_c) begin
            for (int i = 0; i < 4; i++) begin
                if (bus_wstrb[i]) begin
                    mem[bus_idx[AW-1:0]][8*i +: 8] <= bus_wdata[8*i +: 8];
                end
            end
        end
        if (init_we && init_ok_c) begin
            mem[init_idx[AW-1:0]] <= init_data;
        end
    end

    // Read sample register; out-of-range reads capture zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_ok_c ? mem[rd_idx[AW-1:0]] : 32'h0;
        end
    end

endmodule

// File: rtl/mrv32_dmem_responder.sv
// Slave end of the LSU b_* bus: immediate strobed writes, fixed-latency
// read responses, sticky error on reads that arrive while one is pending.
module mrv32_dmem_responder #(
    parameter int unsigned MEM_BYTES  = mrv32_pkg::MEM_BYTES,
    parameter int unsigned ADDR_WIDTH = mrv32_pkg::ADDR_WIDTH,
    parameter int unsigned RD_LATENCY = mrv32_pkg::RD_LATENCY_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  b_valid,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [31:0]           b_wdata,
    input  logic [3:0]            b_wstrb,
    output logic [31:0]           b_rdata,
    output logic                  b_rvalid,
    input  logic                  init_we,
    input  logic [ADDR_WIDTH-3:0] init_addr,
    input  logic [31:0]           init_data,
    output logic                  busy,
    output logic                  err
);

    import mrv32_pkg::*;

    localparam int unsigned MEM_WORDS = MEM_BYTES / 4;
    localparam int unsigned IDX_WIDTH = ADDR_WIDTH - 2;
    localparam int unsigned CNT_WIDTH = 3;
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(RD_LATENCY - 1);

    rsp_state_t           state_q;
    rsp_state_t           state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 err_d;
    logic                 rd_en_c;
    logic                 read_req_c;
    logic                 write_req_c;
    logic [IDX_WIDTH-1:0] widx_c;
    logic [31:0]          rd_q;
    logic [1:0]           unused_addr_lsb;

    assign widx_c          = b_addr[ADDR_WIDTH-1:2];
    assign unused_addr_lsb = b_addr[1:0];
    assign read_req_c      = b_valid && (b_wstrb == WSTRB_NONE);
    assign write_req_c     = b_valid && (b_wstrb != WSTRB_NONE);

    mrv32_dmem_bank #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_we    (write_req_c),
        .bus_idx   (widx_c),
        .bus_wstrb (b_wstrb),
        .bus_wdata (b_wdata),
        .init_we   (init_we),
        .init_idx  (init_addr),
        .init_data (init_data),
        .rd_en     (rd_en_c),
        .rd_idx    (widx_c),
        .rd_data   (rd_q)
    );

    // Response FSM: a read is accepted when idle or on the response cycle itself.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err;
        rd_en_c = 1'b0;
        case (state_q)
            RSP_IDLE: begin
                if (read_req_c) begin
                    state_d = RSP_WAIT;
                    cnt_d   = CNT_LOAD;
                    rd_en_c = 1'b1;
                end
            end
            RSP_WAIT: begin
                if (cnt_q == '0) begin
                    if (read_req_c) begin
                        cnt_d   = CNT_LOAD;
                        rd_en_c = 1'b1;
                    end else begin
                        state_d = RSP_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                    if (read_req_c) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = RSP_IDLE;
            end
        endcase
    end

    // State, counter and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RSP_IDLE;
            cnt_q    <= '0;
            err      <= 1'b0;
            b_rvalid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err      <= err_d;
            b_rvalid <= (state_d == RSP_WAIT) && (cnt_d == '0);
            busy     <= (state_d == RSP_WAIT);
        end
    end

    // Read data is only driven during the response strobe.
    assign b_rdata = b_rvalid ? rd_q : 32'h0;

endmodule

// File: tb/tb_mrv32_dmem_responder.sv
// Three responders (latency 1, 3, 4) share one stimulus stream and are each
// compared every cycle against a cycle-count/queue model of the bus rules.
module tb_mrv32_dmem_responder;

    import mrv32_pkg::*;

    localparam int unsigned NDUT      = 3;
    localparam int unsigned MEM_WORDS = MEM_BYTES / 4;
    localparam int unsigned IDXW      = ADDR_WIDTH - 2;

    function automatic int unsigned lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  b_valid = 1'b0;
    logic [ADDR_WIDTH-1:0] b_addr = '0;
    logic [31:0]           b_wdata = '0;
    logic [3:0]            b_wstrb = '0;
    logic                  init_we = 1'b0;
    logic [IDXW-1:0]       init_addr = '0;
    logic [31:0]           init_data = '0;

    logic [31:0] rdata_w  [NDUT];
    logic        rvalid_w [NDUT];
    logic        busy_w   [NDUT];
    logic        err_w    [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mrv32_dmem_responder #(
            .MEM_BYTES  (MEM_BYTES),
            .ADDR_WIDTH (ADDR_WIDTH),
            .RD_LATENCY ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .b_valid   (b_valid),
            .b_addr    (b_addr),
            .b_wdata   (b_wdata),
            .b_wstrb   (b_wstrb),
            .b_rdata   (rdata_w[g]),
            .b_rvalid  (rvalid_w[g]),
            .init_we   (init_we),
            .init_addr (init_addr),
            .init_data (init_data),
            .busy      (busy_w[g]),
            .err       (err_w[g])
        );
    end

    // Reference model: memory image, one pending response per DUT with the
    // edge number after which its strobe shows, and sticky error flags.
    logic [31:0] ref_mem [MEM_WORDS];
    bit          pend    [NDUT];
    longint      due     [NDUT];
    logic [31:0] pdata   [NDUT];
    bit          ref_err [NDUT];
    longint      edge_n = 0;

    int    n_checks = 0;
    int    n_pass   = 0;
    string phase    = "reset";

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s/%s: got %h expected %h", phase, tag, got, exp);
    endtask

    task automatic model_clear();
        for (int k = 0; k < NDUT; k++) begin
            pend[k]    = 1'b0;
            ref_err[k] = 1'b0;
            pdata[k]   = '0;
        end
    endtask

    // Applies the bus/init inputs currently driven to the model for the next edge.
    task automatic model_edge();
        int unsigned w;
        bit          rd;
        bit          inr;
        bit          fire;
        w   = 32'(b_addr[ADDR_WIDTH-1:2]);
        rd  = b_valid && (b_wstrb == 4'b0000);
        inr = (w < MEM_WORDS);
        for (int k = 0; k < NDUT; k++) begin
            fire = pend[k] && (due[k] == edge_n);
            if (rd) begin
                if (!pend[k] || fire) begin
                    pend[k]  = 1'b1;
                    due[k]   = edge_n + longint'(lat_of(k));
                    pdata[k] = inr ? ref_mem[w] : 32'h0;
                end else begin
                    ref_err[k] = 1'b1;
                end
            end else if (fire) begin
                pend[k] = 1'b0;
            end
        end
        if (b_valid && (b_wstrb != 4'b0000) && inr) begin
            for (int l = 0; l < 4; l++) begin
                if (b_wstrb[l]) ref_mem[w][8*l +: 8] = b_wdata[8*l +: 8];
            end
        end
        if (init_we && (32'(init_addr) < MEM_WORDS)) ref_mem[32'(init_addr)] = init_data;
    endtask

    task automatic check_outputs();
        bit exp_rv;
        for (int k = 0; k < NDUT; k++) begin
            exp_rv = pend[k] && (due[k] == edge_n);
            chk($sformatf("rvalid_L%0d", lat_of(k)), 32'(rvalid_w[k]), 32'(exp_rv));
            chk($sformatf("rdata_L%0d", lat_of(k)), rdata_w[k], exp_rv ? pdata[k] : 32'h0);
            chk($sformatf("busy_L%0d", lat_of(k)), 32'(busy_w[k]), 32'(pend[k]));
            chk($sformatf("err_L%0d", lat_of(k)), 32'(err_w[k]), 32'(ref_err[k]));
        end
    endtask

    task automatic idle_inputs();
        b_valid = 1'b0;
        b_wstrb = 4'b0000;
        init_we = 1'b0;
    endtask

    // One clock: model update, edge, sample 1 time unit later, compare.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        edge_n++;
        check_outputs();
        idle_inputs();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic bus_write(input int unsigned addr, input logic [31:0] data, input logic [3:0] strb);
        b_valid = 1'b1;
        b_addr  = ADDR_WIDTH'(addr);
        b_wdata = data;
        b_wstrb = strb;
        step();
    endtask

    task automatic bus_read(input int unsigned addr);
        b_valid = 1'b1;
        b_addr  = ADDR_WIDTH'(addr);
        b_wdata = $urandom;
        b_wstrb = 4'b0000;
        step();
    endtask

    // Asynchronous reset pulse applied mid-cycle, held across one edge.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        model_clear();
        check_outputs();
        @(posedge clk);
        #1;
        edge_n++;
        rst_n = 1'b1;
        check_outputs();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int unsigned idx;
        model_clear();
        idle_inputs();
        #1;
        do_reset();

        phase = "init_fill";
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            init_we   = 1'b1;
            init_addr = IDXW'(i);
            init_data = $urandom;
            step();
        end

        phase = "sw_read";
        bus_write(32'h10, 32'hDEADBEEF, WSTRB_W);
        bus_read(32'h10);
        chk("sw_rvalid_L1", 32'(rvalid_w[0]), 32'd1);
        chk("sw_rdata_L1", rdata_w[0], 32'hDEADBEEF);
        idle(5);

        phase = "sb_read";
        bus_write(32'h10, 32'h000000AA, WSTRB_B);
        bus_read(32'h12);
        chk("sb_rdata_L1", rdata_w[0], 32'hDEADBEAA);
        idle(5);

        phase = "lat4";
        bus_read(32'h14);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("lat4_rvalid_%0d", i), 32'(rvalid_w[2]), 32'(i == 3));
            chk($sformatf("lat4_busy_%0d", i), 32'(busy_w[2]), 32'(i < 4));
            if (i < 4) step();
        end
        idle(3);

        phase = "overlap";
        do_reset();
        seen = 0;
        bus_read(32'h20);
        seen += int'(rvalid_w[1]);
        bus_read(32'h20);
        seen += int'(rvalid_w[1]);
        for (int i = 0; i < 5; i++) begin
            step();
            seen += int'(rvalid_w[1]);
        end
        chk("overlap_rvalid_count_L3", 32'(seen), 32'd1);
        chk("overlap_err_L3", 32'(err_w[1]), 32'd1);
        chk("overlap_err_L1", 32'(err_w[0]), 32'd0);

        phase = "oor";
        do_reset();
        bus_write(MEM_BYTES, 32'h12345678, WSTRB_W);
        bus_read(MEM_BYTES);
        chk("oor_rvalid_L1", 32'(rvalid_w[0]), 32'd1);
        chk("oor_rdata_L1", rdata_w[0], 32'h0);
        chk("oor_err_L1", 32'(err_w[0]), 32'd0);
        idle(5);
        bus_read(32'h0);
        idle(5);

        phase = "reset_mid_read";
        bus_read(32'h30);
        step();
        do_reset();
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen += int'(rvalid_w[2]);
        end
        chk("rst_no_rvalid_L4", 32'(seen), 32'd0);
        chk("rst_busy_L4", 32'(busy_w[2]), 32'd0);
        chk("rst_err_L4", 32'(err_w[2]), 32'd0);
        init_we   = 1'b1;
        init_addr = IDXW'(32'h30 >> 2);
        init_data = 32'hCAFEF00D;
        step();
        bus_read(32'h30);
        chk("init_rdata_L1", rdata_w[0], 32'hCAFEF00D);
        idle(5);

        phase = "random";
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end
            idx     = $urandom_range(0, MEM_WORDS + 3);
            b_valid = ($urandom_range(0, 1) == 1);
            b_addr  = ADDR_WIDTH'(idx * 4 + $urandom_range(0, 3));
            b_wdata = $urandom;
            case ($urandom_range(0, 5))
                0, 1, 2: b_wstrb = 4'b0000;
                3:       b_wstrb = WSTRB_H;
                4:       b_wstrb = WSTRB_W;
                default: b_wstrb = 4'($urandom);
            endcase
            init_we   = ($urandom_range(0, 7) == 0);
            init_addr = ($urandom_range(0, 1) == 1) ? IDXW'(idx)
                                                    : IDXW'($urandom_range(0, MEM_WORDS + 3));
            init_data = $urandom;
            step();
        end
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
